// File: rtl/clkdiv_pkg.sv
// Shared types and default constants for the divided-clock checker.
package clkdiv_pkg;
    typedef enum logic [1:0] {IDLE, SYNC, MEAS_HIGH, MEAS_LOW} state_e;

    localparam int N_MAX_DEF    = 15;
    localparam int TIMEOUT_DEF  = 64;
    localparam int LOCK_CNT_DEF = 4;
    localparam int ERR_W_DEF    = 8;
endpackage

// File: rtl/clkdiv_checker_if.sv
// Control/status bundle between the checker and whoever drives and observes it.
interface clkdiv_checker_if #(
    parameter int N_MAX   = clkdiv_pkg::N_MAX_DEF,
    parameter int TIMEOUT = clkdiv_pkg::TIMEOUT_DEF,
    parameter int ERR_W   = clkdiv_pkg::ERR_W_DEF
);
    localparam int CFG_W = $clog2(N_MAX + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic             en;
    logic [CFG_W-1:0] cfg_n;
    logic             div_in;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic             meas_valid;
    logic             match;
    logic             lock;
    logic             err;
    logic             stuck;
    logic             cfg_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output en, cfg_n, div_in,
        input  rise, fall, high_cnt, low_cnt, meas_valid, match, lock,
               err, stuck, cfg_err, err_count
    );

    modport slave (
        input  en, cfg_n, div_in,
        output rise, fall, high_cnt, low_cnt, meas_valid, match, lock,
               err, stuck, cfg_err, err_count
    );
endinterface

// File: rtl/clkdiv_checker_edge_det.sv
// Edge detector for a clk-synchronous level: combinational edge flags plus
// registered one-cycle rise/fall pulses.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_now,
    output logic fall_now,
    output logic edge_now,
    output logic rise,
    output logic fall
);
    logic din_prev;

    assign rise_now = din & ~din_prev;
    assign fall_now = ~din & din_prev;
    assign edge_now = din ^ din_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_prev <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            din_prev <= din;
            rise     <= rise_now;
            fall     <= fall_now;
        end
    end
endmodule

// File: rtl/clkdiv_checker.sv
// Measures high/low phase lengths of a divided clock sampled in the clk domain
// and reports match, lock, mismatch errors and stuck-clock timeouts.
module clkdiv_checker
    import clkdiv_pkg::*;
#(
    parameter int N_MAX    = N_MAX_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int ERR_W    = ERR_W_DEF
) (
    input logic             clk,
    input logic             rst,
    clkdiv_checker_if.slave bus
);
    localparam int CFG_W = $clog2(N_MAX + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int STK_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);

    state_e           state;
    logic [CFG_W-1:0] cap_n;
    logic [CNT_W-1:0] ph_cnt, high_cnt_q, low_cnt_q;
    logic [STK_W-1:0] streak;
    logic [ERR_W-1:0] err_count_q;
    logic             meas_valid_q, match_q, lock_q, err_q, stuck_q, cfg_err_q;
    logic             rise_now, fall_now, edge_now, rise_q, fall_q;
    logic             cfg_bad, good, eval, tmo_hit, err_set;

    edge_det u_edge (
        .clk      (clk),
        .rst      (rst),
        .din      (bus.div_in),
        .rise_now (rise_now),
        .fall_now (fall_now),
        .edge_now (edge_now),
        .rise     (rise_q),
        .fall     (fall_q)
    );

    assign cfg_bad = (bus.cfg_n == '0) || (int'(bus.cfg_n) > N_MAX);
    // ph_cnt still holds the low phase length on the closing rising edge
    assign good    = (high_cnt_q == CNT_W'(cap_n)) && (ph_cnt == CNT_W'(cap_n));
    assign eval    = bus.en && (state == MEAS_LOW) && rise_now;
    // ph_cnt saturates at TIMEOUT, so this fires only once per stall
    assign tmo_hit = bus.en && (state != IDLE) && !edge_now && (ph_cnt == TMO_M1);
    assign err_set = (eval && !good) || tmo_hit;

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) ph_cnt <= '0;
        else if (edge_now)        ph_cnt <= CNT_W'(1);
        else if (ph_cnt != TMO)   ph_cnt <= ph_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cap_n        <= '0;
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
            streak       <= '0;
            err_count_q  <= '0;
            meas_valid_q <= 1'b0;
            match_q      <= 1'b0;
            lock_q       <= 1'b0;
            err_q        <= 1'b0;
            stuck_q      <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            err_q        <= err_set;
            stuck_q      <= tmo_hit;
            if (err_set && err_count_q != '1) err_count_q <= err_count_q + 1'b1;

            if (!bus.en) begin
                state     <= IDLE;
                lock_q    <= 1'b0;
                streak    <= '0;
                cfg_err_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (!cfg_err_q) begin
                        cap_n <= bus.cfg_n;
                        if (cfg_bad) cfg_err_q <= 1'b1;
                        else         state     <= SYNC;
                    end
                    SYNC: if (rise_now) state <= MEAS_HIGH;
                    MEAS_HIGH: if (fall_now) begin
                        high_cnt_q <= ph_cnt;
                        state      <= MEAS_LOW;
                    end
                    MEAS_LOW: if (rise_now) begin
                        low_cnt_q    <= ph_cnt;
                        meas_valid_q <= 1'b1;
                        match_q      <= good;
                        state        <= MEAS_HIGH;
                        if (good) begin
                            if (streak != STK_W'(LOCK_CNT)) streak <= streak + 1'b1;
                            lock_q <= (streak >= STK_W'(LOCK_CNT - 1));
                        end else begin
                            streak <= '0;
                            lock_q <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (tmo_hit) begin
                    state  <= SYNC;
                    streak <= '0;
                    lock_q <= 1'b0;
                end
            end
        end
    end

    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.high_cnt   = high_cnt_q;
    assign bus.low_cnt    = low_cnt_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.match      = match_q;
    assign bus.lock       = lock_q;
    assign bus.err        = err_q;
    assign bus.stuck      = stuck_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.err_count  = err_count_q;
endmodule
